// File: rtl/a10_mac_pkg.sv
// rtl/a10_mac_pkg.sv - shared widths and pipeline stage record for the dot-product issuer
package a10_mac_pkg;

  localparam int OPND_W = 8;
  localparam int PROD_W = 17;

  typedef struct packed {
    logic              valid;
    logic              first;
    logic              last;
    logic [PROD_W-1:0] p;
  } mac_stage_t;

endpackage

// File: rtl/a10_mac_pair_pipe.sv
// rtl/a10_mac_pair_pipe.sv - two signed 8x8 multiplies plus add, carried through MAC_LATENCY gated stages
module a10_mac_pair_pipe
  import a10_mac_pkg::*;
#(
  parameter int MAC_LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_en,
  input  logic              i_valid,
  input  logic              i_first,
  input  logic              i_last,
  input  logic [OPND_W-1:0] i_a0,
  input  logic [OPND_W-1:0] i_b0,
  input  logic [OPND_W-1:0] i_a1,
  input  logic [OPND_W-1:0] i_b1,
  output mac_stage_t        o_tail
);

  logic signed [2*OPND_W-1:0] w_prod0;
  logic signed [2*OPND_W-1:0] w_prod1;
  logic [PROD_W-1:0]          w_p;
  mac_stage_t                 r_stage [MAC_LATENCY];

  assign w_prod0 = $signed(i_a0) * $signed(i_b0);
  assign w_prod1 = $signed(i_a1) * $signed(i_b1);
  // One extra sign bit makes the pair sum exact for every operand combination.
  assign w_p     = {w_prod0[2*OPND_W-1], w_prod0} + {w_prod1[2*OPND_W-1], w_prod1};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MAC_LATENCY; i++) begin
        r_stage[i] <= '0;
      end
    end else if (i_en) begin
      r_stage[0] <= '{valid: i_valid, first: i_first, last: i_last, p: w_p};
      for (int i = 1; i < MAC_LATENCY; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_tail = r_stage[MAC_LATENCY-1];

endmodule

// File: rtl/a10_mac_dot_issuer.sv
// rtl/a10_mac_dot_issuer.sv - beat counter, accumulator and output register around the pair-product pipe
module a10_mac_dot_issuer
  import a10_mac_pkg::*;
#(
  parameter int MAC_LATENCY = 2,
  parameter int ACC_W       = 32,
  parameter int LEN_W       = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPND_W-1:0] in_a0,
  input  logic [OPND_W-1:0] in_b0,
  input  logic [OPND_W-1:0] in_a1,
  input  logic [OPND_W-1:0] in_b1,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_result
);

  mac_stage_t               w_tail;
  logic                     w_stall;
  logic                     w_accept;
  logic                     w_first;
  logic                     w_last;
  logic                     w_load;
  logic [LEN_W-1:0]         w_len_cur;
  logic signed [PROD_W-1:0] w_tail_p;
  logic signed [ACC_W-1:0]  w_p_ext;
  logic [ACC_W-1:0]         w_acc_next;

  logic [LEN_W-1:0]         r_count;
  logic [LEN_W-1:0]         r_len;
  logic [ACC_W-1:0]         r_acc;
  logic [ACC_W-1:0]         r_result;
  logic                     r_out_valid;

  // Only a finished result that cannot leave the tail blocks the whole pipe.
  assign w_stall  = w_tail.valid && w_tail.last && r_out_valid && !out_ready;
  assign in_ready = !w_stall;
  assign w_accept = in_valid && !w_stall;

  assign w_first   = (r_count == '0);
  assign w_len_cur = w_first ? ((cfg_len == '0) ? LEN_W'(1) : cfg_len) : r_len;
  assign w_last    = (r_count == w_len_cur - LEN_W'(1));

  a10_mac_pair_pipe #(
    .MAC_LATENCY (MAC_LATENCY)
  ) u_pipe (
    .clock   (clock),
    .reset   (reset),
    .i_en    (!w_stall),
    .i_valid (w_accept),
    .i_first (w_first),
    .i_last  (w_last),
    .i_a0    (in_a0),
    .i_b0    (in_b0),
    .i_a1    (in_a1),
    .i_b1    (in_b1),
    .o_tail  (w_tail)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_len   <= '0;
    end else if (w_accept) begin
      if (w_first) begin
        r_len <= w_len_cur;
      end
      r_count <= w_last ? '0 : r_count + LEN_W'(1);
    end
  end

  assign w_tail_p   = w_tail.p;
  assign w_p_ext    = ACC_W'(w_tail_p);
  assign w_acc_next = (w_tail.first ? '0 : r_acc) + w_p_ext;
  assign w_load     = w_tail.valid && w_tail.last && !w_stall;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_acc       <= '0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_tail.valid && !w_stall) begin
        r_acc <= w_tail.last ? '0 : w_acc_next;
      end
      // A new result may replace the one being handed off in the same cycle.
      if (w_load) begin
        r_result    <= w_acc_next;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_result = r_result;

endmodule

// File: tb/tb_a10_mac_dot_issuer.sv
// tb/tb_a10_mac_dot_issuer.sv - directed self-checking bench for a10_mac_dot_issuer
module tb_a10_mac_dot_issuer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cfg_len = 16'd1;
  logic        in_valid = 1'b0;
  logic        in_valid_b = 1'b0;
  logic [7:0]  in_a0 = '0, in_b0 = '0, in_a1 = '0, in_b1 = '0;
  logic        out_ready = 1'b1;
  logic        in_ready, out_valid;
  logic [31:0] out_result;
  logic        in_ready_b, out_valid_b;
  logic [16:0] out_result_b;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [31:0] q_a [$];
  logic [31:0] q_b [$];
  int          q_cyc [$];
  logic        seen_in_ready_low;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  a10_mac_dot_issuer u_dut (
    .clock      (clock),
    .reset      (reset),
    .cfg_len    (cfg_len),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a0      (in_a0),
    .in_b0      (in_b0),
    .in_a1      (in_a1),
    .in_b1      (in_b1),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
  );

  a10_mac_dot_issuer #(.ACC_W(17)) u_dut17 (
    .clock      (clock),
    .reset      (reset),
    .cfg_len    (cfg_len),
    .in_valid   (in_valid_b),
    .in_ready   (in_ready_b),
    .in_a0      (in_a0),
    .in_b0      (in_b0),
    .in_a1      (in_a1),
    .in_b1      (in_b1),
    .out_valid  (out_valid_b),
    .out_ready  (out_ready),
    .out_result (out_result_b)
  );

  always @(negedge clock) begin
    if (out_valid && out_ready) begin
      q_a.push_back(out_result);
      q_cyc.push_back(cyc);
    end
    if (out_valid_b && out_ready) q_b.push_back({{15{out_result_b[16]}}, out_result_b});
    if (!in_ready) seen_in_ready_low = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input bit sel, input int a0, input int b0, input int a1, input int b1);
    int   k;
    logic rdy;
    in_a0 = 8'(a0); in_b0 = 8'(b0); in_a1 = 8'(a1); in_b1 = 8'(b1);
    if (sel) in_valid_b = 1'b1; else in_valid = 1'b1;
    k = 0;
    do begin
      @(negedge clock);
      rdy = sel ? in_ready_b : in_ready;
      k++;
    end while (!rdy && k < 60);
    if (!rdy) chk("send_timeout", 32'(rdy), 32'd1);
    @(posedge clock);
    #1;
    in_valid   = 1'b0;
    in_valid_b = 1'b0;
  endtask

  task automatic wait_results(input bit sel, input int n);
    int k = 0;
    while ((sel ? q_b.size() : q_a.size()) < n && k < 100) begin
      tick();
      k++;
    end
  endtask

  task automatic pop_chk(input bit sel, input string tag, input logic [31:0] exp);
    logic [31:0] v;
    if (sel) v = (q_b.size() > 0) ? q_b.pop_front() : 32'hBAD0_BAD0;
    else     v = (q_a.size() > 0) ? q_a.pop_front() : 32'hBAD0_BAD0;
    chk(tag, v, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    tick();

    // single-beat group, latency to out_valid
    cfg_len = 16'd1;
    send(0, 3, 4, -2, 5);
    chk("lat_c1_valid", 32'(out_valid), 32'd0);
    tick();
    chk("lat_c2_valid", 32'(out_valid), 32'd0);
    tick();
    chk("lat_c3_valid", 32'(out_valid), 32'd1);
    chk("lat_c3_result", out_result, 32'd2);
    repeat (3) tick();
    q_a.delete();

    // zero length behaves as one
    cfg_len = 16'd0;
    send(0, 1, 1, 1, 1);
    wait_results(0, 1);
    pop_chk(0, "len0_result", 32'd2);

    // four most-negative beats; mid-group cfg_len change ignored
    cfg_len = 16'd4;
    send(0, -128, -128, -128, -128);
    cfg_len = 16'd1;
    repeat (3) send(0, -128, -128, -128, -128);
    wait_results(0, 1);
    pop_chk(0, "len4_result", 32'd131072);
    repeat (6) tick();
    chk("len4_single", 32'(q_a.size()), 32'd0);

    // back-to-back single-beat groups, one result per cycle
    cfg_len = 16'd1;
    q_cyc.delete();
    for (int g = 1; g <= 4; g++) send(0, g, 1, 0, 0);
    wait_results(0, 4);
    if (q_cyc.size() >= 4) chk("b2b_spacing", 32'(q_cyc[3] - q_cyc[0]), 32'd3);
    else chk("b2b_count", 32'(q_cyc.size()), 32'd4);
    for (int g = 1; g <= 4; g++) pop_chk(0, "b2b_result", 32'(g));

    // backpressure with len=2 groups
    cfg_len = 16'd2;
    out_ready = 1'b0;
    seen_in_ready_low = 1'b0;
    fork
      begin
        for (int g = 1; g <= 4; g++) begin
          send(0, g, 2, 0, 0);
          send(0, g, 1, 0, 0);
        end
      end
      begin
        repeat (10) tick();
        chk("bp_hold_empty", 32'(q_a.size()), 32'd0);
        chk("bp_hold_result", out_result, 32'd3);
        chk("bp_in_ready_low", 32'(seen_in_ready_low), 32'd1);
        out_ready = 1'b1;
      end
    join
    wait_results(0, 4);
    for (int g = 1; g <= 4; g++) pop_chk(0, "bp_result", 32'(3 * g));
    repeat (6) tick();
    chk("bp_no_dup", 32'(q_a.size()), 32'd0);

    // 17-bit accumulator wraps
    cfg_len = 16'd3;
    repeat (3) send(1, 127, 127, 127, 127);
    wait_results(1, 1);
    pop_chk(1, "wrap17_result", 32'hFFFF_7A06);

    // reset in the middle of a group with a pending result
    out_ready = 1'b0;
    cfg_len = 16'd1;
    send(0, 1, 1, 0, 0);
    repeat (3) tick();
    chk("mid_pending_valid", 32'(out_valid), 32'd1);
    cfg_len = 16'd4;
    send(0, 10, 1, 0, 0);
    send(0, 10, 1, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clock);
    reset = 1'b0;
    tick();
    out_ready = 1'b1;
    repeat (4) send(0, 5, 1, 0, 0);
    wait_results(0, 1);
    pop_chk(0, "mid_new_group", 32'd20);
    repeat (6) tick();
    chk("mid_no_extra", 32'(q_a.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
